// File: rtl/ibexc_trace_pkg.sv
// Shared types for the RVFI trace packer: record layout, word-index enum, header packing.
// IBEXC_TRACE_MEM_EN adds mem_addr to the record and a fifth packet word.
package ibexc_trace_pkg;

  localparam logic [7:0] TraceSyncByte = 8'hA5;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_HDR   = 3'd1,
    W_PC    = 3'd2,
    W_INSN  = 3'd3,
    W_WDATA = 3'd4,
    W_MEM   = 3'd5
  } trace_word_e;

  typedef struct packed {
    logic [7:0]  order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic        mem_access;
`ifdef IBEXC_TRACE_MEM_EN
    logic [31:0] mem_addr;
`endif
    logic [7:0]  drops;
  } trace_rec_t;

  localparam int TraceRecW = $bits(trace_rec_t);

  function automatic logic [31:0] pack_header(input trace_rec_t r);
    return {TraceSyncByte, r.drops, r.rd_addr, r.trap, r.intr, r.mode,
            r.mem_access, r.order[5:0]};
  endfunction

endpackage

// File: rtl/ibexc_trace_fifo.sv
// Generic synchronous FIFO with registered occupancy; head entry is read combinationally.
// Push is refused when full on pre-pop occupancy; pop is ignored when empty.
module ibexc_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign full_o    = (r_level == LW'(DEPTH));
  assign empty_o   = (r_level == '0);
  assign level_o   = r_level;
  assign rdata_o   = r_mem[r_rd_ptr];
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
      else if (!w_do_push && w_do_pop) r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/ibexc_rvfi_trace_packer.sv
// Captures RVFI retirements into a record FIFO and serialises each into a 32-bit word packet.
// IBEXC_TRACE_MEM_EN appends mem_addr as a fifth word for memory-accessing records.
module ibexc_rvfi_trace_packer
  import ibexc_trace_pkg::*;
#(
  parameter int Depth    = 8,
  parameter int DropCntW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       trace_en_i,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  input  logic [1:0]                 rvfi_mode_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_mem_addr_i,
  input  logic [3:0]                 rvfi_mem_rmask_i,
  input  logic [3:0]                 rvfi_mem_wmask_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_data_o,
  output logic                       trace_last_o,
  output logic [$clog2(Depth+1)-1:0] fifo_level_o,
  output logic [DropCntW-1:0]        drop_total_o,
  output logic [2:0]                 dbg_word_o
);

  localparam int LW = $clog2(Depth + 1);

  trace_word_e          r_word;
  logic [7:0]           r_pending_drop;
  logic [DropCntW-1:0]  r_drop_total;
  trace_rec_t           w_rec;
  trace_rec_t           w_head;
  logic [TraceRecW-1:0] w_head_bits;
  logic                 w_cap;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [LW-1:0]        w_level;
  trace_word_e          w_after_pop;

`ifdef IBEXC_TRACE_MEM_EN
  logic [55:0] w_unused_order;
  assign w_unused_order = rvfi_order_i[63:8];
`else
  logic [87:0] w_unused_order;
  assign w_unused_order = {rvfi_order_i[63:8], rvfi_mem_addr_i};
`endif

  assign w_cap  = rvfi_valid_i & trace_en_i;
  assign w_push = w_cap & ~w_full;

  always_comb begin
    w_rec            = '0;
    w_rec.order      = rvfi_order_i[7:0];
    w_rec.pc         = rvfi_pc_rdata_i;
    w_rec.insn       = rvfi_insn_i;
    w_rec.rd_addr    = rvfi_rd_addr_i;
    w_rec.rd_wdata   = rvfi_rd_wdata_i;
    w_rec.trap       = rvfi_trap_i;
    w_rec.intr       = rvfi_intr_i;
    w_rec.mode       = rvfi_mode_i;
    w_rec.mem_access = |(rvfi_mem_rmask_i | rvfi_mem_wmask_i);
`ifdef IBEXC_TRACE_MEM_EN
    w_rec.mem_addr   = rvfi_mem_addr_i;
`endif
    w_rec.drops      = r_pending_drop;
  end

  ibexc_trace_fifo #(.W(TraceRecW), .DEPTH(Depth), .LW(LW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .wdata_i (w_rec),
    .pop_i   (w_pop),
    .rdata_o (w_head_bits),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  assign w_head       = trace_rec_t'(w_head_bits);
  assign fifo_level_o = w_level;
  assign drop_total_o = r_drop_total;
  assign dbg_word_o   = r_word;

  // Stream handshake: a word moves only when trace_valid_o & trace_ready_i at the clock
  // edge; until then data/last hold, and valid only falls after a handshake or on reset.
  always_comb begin
    trace_valid_o = (r_word != W_IDLE);
    trace_data_o  = '0;
    trace_last_o  = 1'b0;
    case (r_word)
      W_HDR:   trace_data_o = pack_header(w_head);
      W_PC:    trace_data_o = w_head.pc;
      W_INSN:  trace_data_o = w_head.insn;
      W_WDATA: begin
        trace_data_o = w_head.rd_wdata;
`ifdef IBEXC_TRACE_MEM_EN
        trace_last_o = ~w_head.mem_access;
`else
        trace_last_o = 1'b1;
`endif
      end
      W_MEM: begin
`ifdef IBEXC_TRACE_MEM_EN
        trace_data_o = w_head.mem_addr;
`endif
        trace_last_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_pop       = trace_valid_o & trace_ready_i & trace_last_o;
  // Occupancy after this pop is level-1+push; chain straight into the next header if nonzero.
  assign w_after_pop = ((w_level > LW'(1)) || w_push) ? W_HDR : W_IDLE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word <= W_IDLE;
    end else begin
      case (r_word)
        W_IDLE:  if (w_push || !w_empty) r_word <= W_HDR;
        W_HDR:   if (trace_ready_i) r_word <= W_PC;
        W_PC:    if (trace_ready_i) r_word <= W_INSN;
        W_INSN:  if (trace_ready_i) r_word <= W_WDATA;
        W_WDATA: if (trace_ready_i) r_word <= trace_last_o ? w_after_pop : W_MEM;
        W_MEM:   if (trace_ready_i) r_word <= w_after_pop;
        default: r_word <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending_drop <= '0;
      r_drop_total   <= '0;
    end else if (w_cap && w_full) begin
      if (r_pending_drop != 8'hFF) r_pending_drop <= r_pending_drop + 8'd1;
      if (r_drop_total != '1)      r_drop_total   <= r_drop_total + DropCntW'(1);
    end else if (w_push) begin
      r_pending_drop <= '0;
    end
  end

endmodule

// File: tb/tb_ibexc_rvfi_trace_packer.sv
// Directed scoreboard bench for ibexc_rvfi_trace_packer; a negedge monitor pops expected words.
// Builds with or without IBEXC_TRACE_MEM_EN.
module tb_ibexc_rvfi_trace_packer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        trace_en_i = 1'b1;
  logic        rvfi_valid_i = 1'b0;
  logic [63:0] rvfi_order_i = '0;
  logic [31:0] rvfi_insn_i = '0;
  logic        rvfi_trap_i = 1'b0;
  logic        rvfi_intr_i = 1'b0;
  logic [1:0]  rvfi_mode_i = '0;
  logic [4:0]  rvfi_rd_addr_i = '0;
  logic [31:0] rvfi_rd_wdata_i = '0;
  logic [31:0] rvfi_pc_rdata_i = '0;
  logic [31:0] rvfi_mem_addr_i = '0;
  logic [3:0]  rvfi_mem_rmask_i = '0;
  logic [3:0]  rvfi_mem_wmask_i = '0;
  logic        trace_valid_o;
  logic        trace_ready_i = 1'b1;
  logic [31:0] trace_data_o;
  logic        trace_last_o;
  logic [3:0]  fifo_level_o;
  logic [15:0] drop_total_o;
  logic [2:0]  dbg_word_o;

  logic [32:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        stalled = 1'b0;
  logic [32:0] stall_word = '0;

  ibexc_rvfi_trace_packer #(.Depth(8), .DropCntW(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .trace_en_i       (trace_en_i),
    .rvfi_valid_i     (rvfi_valid_i),
    .rvfi_order_i     (rvfi_order_i),
    .rvfi_insn_i      (rvfi_insn_i),
    .rvfi_trap_i      (rvfi_trap_i),
    .rvfi_intr_i      (rvfi_intr_i),
    .rvfi_mode_i      (rvfi_mode_i),
    .rvfi_rd_addr_i   (rvfi_rd_addr_i),
    .rvfi_rd_wdata_i  (rvfi_rd_wdata_i),
    .rvfi_pc_rdata_i  (rvfi_pc_rdata_i),
    .rvfi_mem_addr_i  (rvfi_mem_addr_i),
    .rvfi_mem_rmask_i (rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i (rvfi_mem_wmask_i),
    .trace_valid_o    (trace_valid_o),
    .trace_ready_i    (trace_ready_i),
    .trace_data_o     (trace_data_o),
    .trace_last_o     (trace_last_o),
    .fifo_level_o     (fifo_level_o),
    .drop_total_o     (drop_total_o),
    .dbg_word_o       (dbg_word_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Monitor: pop/compare on each handshake, and hold-stability while stalled.
  always @(negedge clk) begin
    if (rst_i) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", trace_valid_o, 1'b1);
        check("stall_word", {trace_last_o, trace_data_o}, stall_word);
      end
      if (trace_valid_o && trace_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", {trace_last_o, trace_data_o});
        end else begin
          check("stream_word", {trace_last_o, trace_data_o}, exp_q.pop_front());
        end
      end
      stalled    = trace_valid_o && !trace_ready_i;
      stall_word = {trace_last_o, trace_data_o};
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] insn,
                        input logic [4:0] rd, input logic [31:0] wd, input logic trap,
                        input logic intr, input logic [1:0] mode, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] ma, input bit exp_push,
                        input logic [31:0] hdr, input bit has_w4);
    rvfi_valid_i     = 1'b1;
    rvfi_order_i     = order;
    rvfi_pc_rdata_i  = pc;
    rvfi_insn_i      = insn;
    rvfi_rd_addr_i   = rd;
    rvfi_rd_wdata_i  = wd;
    rvfi_trap_i      = trap;
    rvfi_intr_i      = intr;
    rvfi_mode_i      = mode;
    rvfi_mem_rmask_i = rm;
    rvfi_mem_wmask_i = wm;
    rvfi_mem_addr_i  = ma;
    if (exp_push) begin
      exp_q.push_back({1'b0, hdr});
      exp_q.push_back({1'b0, pc});
      exp_q.push_back({1'b0, insn});
      exp_q.push_back({~has_w4, wd});
      if (has_w4) exp_q.push_back({1'b1, ma});
    end
    tick();
    rvfi_valid_i = 1'b0;
  endtask

  task automatic wait_drain(output int n);
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    bit mem_w4;
`ifdef IBEXC_TRACE_MEM_EN
    mem_w4 = 1'b1;
`else
    mem_w4 = 1'b0;
`endif
    tick();
    tick();
    check("rst_valid", trace_valid_o, 1'b0);
    check("rst_data", trace_data_o, 32'h0);
    check("rst_last", trace_last_o, 1'b0);
    check("rst_level", fifo_level_o, 4'd0);
    check("rst_drops", drop_total_o, 16'd0);
    rst_i = 1'b0;
    tick();

    // Single retirement, ready high: header in the cycle after capture, 4 consecutive words.
    retire(64'd5, 32'h0010_0080, 32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 2'd3,
           4'h0, 4'h0, 32'h0, 1'b1, 32'hA500_0185, 1'b0);
    @(negedge clk);
    check("lat_valid", trace_valid_o, 1'b1);
    check("lat_hdr", trace_data_o, 32'hA500_0185);
    @(posedge clk);
    #1;
    wait_drain(n);
    check("single_cycles", n + 1, 4);
    tick();
    check("single_idle", trace_valid_o, 1'b0);

    // Back-pressure after two words; stall for 10 cycles on the insn word.
    trace_ready_i = 1'b0;
    retire(64'h2A, 32'h0000_4000, 32'h00A0_0293, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0,
           4'h0, 4'h0, 32'h0, 1'b1, 32'hA500_2C2A, 1'b0);
    trace_ready_i = 1'b1;
    tick();
    tick();
    trace_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", trace_valid_o, 1'b1);
      check("bp_data", trace_data_o, 32'h00A0_0293);
      @(posedge clk);
      #1;
    end
    trace_ready_i = 1'b1;
    wait_drain(n);

    // Overflow: 11 retirements into a stalled stream.
    trace_ready_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      retire(64'(i), 32'h100 + 32'(i * 4), 32'h13, 5'd0, 32'(i), 1'b0, 1'b0, 2'd0,
             4'h0, 4'h0, 32'h0, i < 8, 32'hA500_0000 | 32'(i), 1'b0);
      check("ovf_level", fifo_level_o, (i < 8) ? 4'(i + 1) : 4'd8);
    end
    check("ovf_drops", drop_total_o, 16'd3);
    trace_ready_i = 1'b1;
    wait_drain(n);
    retire(64'd11, 32'h200, 32'h33, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0,
           4'h0, 4'h0, 32'h0, 1'b1, 32'hA503_000B, 1'b0);
    wait_drain(n);

    // Push into a full FIFO in the same cycle as the final-word pop.
    trace_ready_i = 1'b0;
    for (int i = 0; i < 8; i++)
      retire(64'h10 + 64'(i), 32'h300 + 32'(i), 32'h13, 5'd0, 32'(i), 1'b0, 1'b0, 2'd0,
             4'h0, 4'h0, 32'h0, 1'b1, 32'hA500_0010 | 32'(i), 1'b0);
    check("full_level", fifo_level_o, 4'd8);
    trace_ready_i = 1'b1;
    tick();
    tick();
    tick();
    retire(64'h18, 32'h400, 32'h13, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0,
           4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("pushpop_level", fifo_level_o, 4'd7);
    check("pushpop_drops", drop_total_o, 16'd4);
    wait_drain(n);

    // Capture disabled: retirements ignored and not counted.
    trace_en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      retire(64'h40 + 64'(i), 32'h500, 32'h13, 5'd1, 32'h1, 1'b0, 1'b0, 2'd3,
             4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      check("dis_valid", trace_valid_o, 1'b0);
    end
    check("dis_level", fifo_level_o, 4'd0);
    check("dis_drops", drop_total_o, 16'd4);
    trace_en_i = 1'b1;

    // Reset while w2 is on the bus.
    retire(64'h21, 32'h600, 32'h0000_0093, 5'd1, 32'h7, 1'b0, 1'b0, 2'd3,
           4'h0, 4'h0, 32'h0, 1'b1, 32'hA501_09A1, 1'b0);
    tick();
    tick();
    check("pre_rst_w2", trace_data_o, 32'h0000_0093);
    rst_i = 1'b1;
    trace_ready_i = 1'b0;
    exp_q.delete();
    tick();
    check("mrst_valid", trace_valid_o, 1'b0);
    check("mrst_last", trace_last_o, 1'b0);
    check("mrst_data", trace_data_o, 32'h0);
    check("mrst_level", fifo_level_o, 4'd0);
    check("mrst_drops", drop_total_o, 16'd0);
    rst_i = 1'b0;
    trace_ready_i = 1'b1;
    tick();

    // Store retirement: header bit 6 set; mem_addr word only with the memory option.
    retire(64'd7, 32'h0000_0700, 32'h00A5_2023, 5'd0, 32'h0, 1'b0, 1'b0, 2'd3,
           4'h0, 4'hF, 32'h2000_0100, 1'b1, 32'hA500_01C7, mem_w4);
    wait_drain(n);
    check("mem_cycles", n, mem_w4 ? 5 : 4);

    repeat (3) tick();
    check("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
